cmp_digit_serial: RTL and testbench
===================================

# cmp_digit_serial

Sequential magnitude comparator that consumes the per-digit {g,l,e} outputs of the 2-bit comparator stage, MSB digit first, and resolves a full-width greater/less/equal result for words of NDIGITS 2-bit digits. It sits directly downstream of the 2-bit comparator. Upstream logic presents one digit pair per accepted transfer, and this block accumulates the outcome and reports it with a done pulse. Compare width scales without widening the combinational comparator.

## Interface
- NDIGITS, 4: number of 2-bit digits per word (legal 1..16; default = 8-bit words)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new compare; honoured only in IDLE
- dig_valid  in  1  upstream digit result valid
- dig_ready  out  1  block accepts a digit this cycle; high only in RUN
- g_in  in  1  digit a > b (from 2-bit comparator g)
- l_in  in  1  digit a < b (from 2-bit comparator l)
- e_in  in  1  digit a == b (from 2-bit comparator e)
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- gt  out  1  word result a > b; held until next completion
- lt  out  1  word result a < b; held until next completion
- eq  out  1  word result a == b; held until next completion
- err  out  1  sticky: an accepted digit was not one-hot; cleared by accepted start

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → RUN. Digit counter is cleared to 0, internal accumulator is set to EQUAL, and err is cleared.
- RUN: a digit is accepted when dig_valid & dig_ready. Each accepted digit increments the counter.
- Accumulator update: if the accumulator is EQUAL and the digit is g → GREATER; if the digit is l → LESS. A digit of e, or any digit once the accumulator is decided, leaves the accumulator unchanged (MSB-first priority).
- Invalid digit: if {g_in,l_in,e_in} is not one-hot on an accepted digit, set err and treat the digit as e.
- Completion: when the counter reaches NDIGITS-1 on an accepted digit → DONE. The accumulator (including the current digit) is registered onto gt/lt/eq, exactly one of which is high.
- DONE: done=1 for one cycle, then unconditional → IDLE. start is ignored in DONE.
- start in RUN or DONE: ignored; no restart.
- dig_valid outside RUN: ignored; no state change.
- Counter width is max(1,$clog2(NDIGITS)). The counter never wraps, because it is cleared on start.
- NDIGITS=1: the first accepted digit completes the compare.

## Timing
- Reset values: state IDLE, dig_ready=0, busy=0, done=0, gt=0, lt=0, eq=0, err=0, counter=0.
- Start accepted at edge N: busy=1 and dig_ready=1 from cycle N+1.
- Last digit accepted at edge T: done=1 and gt/lt/eq updated in cycle T+1. busy=0 and dig_ready=0 from cycle T+1. IDLE from cycle T+2.
- Minimum start-to-done latency: NDIGITS+1 cycles with dig_valid held high. Gaps in dig_valid stall the block without loss.
- A new start is accepted no earlier than cycle T+2.
- rst during RUN or DONE: next cycle IDLE, all outputs at reset values, partial compare discarded, no done.

## Configuration
- CMP_EARLY_EXIT_EN defined: the first accepted g or l digit (valid, one-hot) completes immediately. The block enters DONE with that result, dig_ready drops the following cycle, and remaining upstream digits are not consumed. Upstream is responsible for flushing them. All-e words still take NDIGITS digits.
- Not defined: every compare consumes exactly NDIGITS digits regardless of when the result is decided.

## Structure
- Shared package cmp_pkg holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - accumulator encoding: EQUAL, GREATER, LESS
  - NDIGITS legal-range bounds
- One sub-module is natural: cmp_digit_cnt (clearable, enabled up-counter with terminal-count flag at NDIGITS-1).
- The FSM and accumulator stay in the top module.

## Test plan
- a=8'hA5, b=8'hA5, NDIGITS=4, dig_valid held: four e digits → done at start+5, eq=1, gt=0, lt=0, err=0.
- a=8'hC0, b=8'h40 (MSB digit g, then e,e,e): with CMP_EARLY_EXIT_EN → done one cycle after the first digit, gt=1. Without the macro → done after the fourth digit, gt=1.
- Digits e,l,g,e: lt=1 (the later g is ignored). Insert 2-cycle dig_valid gaps between digits; the result is unchanged and latency grows by 6.
- Second digit {g,l,e}=3'b110: err=1, digit treated as e, and the compare completes normally. The next accepted start clears err.
- rst asserted on the third digit of a run → the next cycle shows all outputs 0 and IDLE with no done pulse. A fresh start then compares correctly.
- NDIGITS=1, single l digit → done at start+2, lt=1. start pulsed during RUN and DONE → ignored.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the digit-serial magnitude comparator: FSM and accumulator
// encodings, legal NDIGITS range and a one-hot check on a {g,l,e} digit.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EQUAL   = 2'd0,
    GREATER = 2'd1,
    LESS    = 2'd2
  } acc_t;

  localparam int NDIGITS_MIN = 1;
  localparam int NDIGITS_MAX = 16;

  function automatic logic is_one_hot3(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

endpackage

// File: rtl/cmp_digit_cnt.sv
// Digit counter: synchronous clear, count enable, terminal-count flag at NDIGITS-1.
// Saturates at the terminal count so it can never wrap.
module cmp_digit_cnt
  import cmp_pkg::*;
#(
  parameter int NDIGITS = 4,
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt_r;

  // digit index register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && !tc) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == CW'(NDIGITS - 1));

endmodule

// File: rtl/cmp_digit_serial.sv
// Digit-serial magnitude comparator, MSB digit first, fed by a 2-bit comparator stage.
// Optional build macro CMP_EARLY_EXIT_EN: finish on the first decisive (g or l) digit.
module cmp_digit_serial
  import cmp_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic dig_valid,
  output logic dig_ready,
  input  logic g_in,
  input  logic l_in,
  input  logic e_in,
  output logic busy,
  output logic done,
  output logic gt,
  output logic lt,
  output logic eq,
  output logic err
);

  localparam int ND = (NDIGITS < NDIGITS_MIN) ? NDIGITS_MIN :
                      (NDIGITS > NDIGITS_MAX) ? NDIGITS_MAX : NDIGITS;

  state_t state_r, state_next_s;
  acc_t   acc_r, acc_next_s;
  logic   dig_ready_r, busy_r, done_r, gt_r, lt_r, eq_r, err_r;
  logic   start_ok_s, accept_s, digit_ok_s, early_s, tc_s, finish_s;

  assign start_ok_s = start && (state_r == IDLE);
  assign accept_s   = dig_valid && dig_ready_r;
  assign digit_ok_s = is_one_hot3({g_in, l_in, e_in});
  assign finish_s   = accept_s && (tc_s || early_s);

  cmp_digit_cnt #(.NDIGITS(ND)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok_s),
    .en  (accept_s),
    .tc  (tc_s)
  );

  // accumulator update: only the first decisive digit counts, malformed digits act as e
  always_comb begin
    acc_next_s = acc_r;
    if ((acc_r == EQUAL) && digit_ok_s && g_in) begin
      acc_next_s = GREATER;
    end else if ((acc_r == EQUAL) && digit_ok_s && l_in) begin
      acc_next_s = LESS;
    end else begin
      acc_next_s = acc_r;
    end
  end

`ifdef CMP_EARLY_EXIT_EN
  assign early_s = (acc_next_s != acc_r);
`else
  assign early_s = 1'b0;
`endif

  // next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = start_ok_s ? RUN : IDLE;
      RUN:     state_next_s = finish_s ? DONE : RUN;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // handshake and status flags registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      dig_ready_r <= (state_next_s == RUN);
      busy_r      <= (state_next_s == RUN);
      done_r      <= (state_next_s == DONE);
    end
  end

  // accumulator and sticky malformed-digit flag
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= EQUAL;
      err_r <= 1'b0;
    end else if (start_ok_s) begin
      acc_r <= EQUAL;
      err_r <= 1'b0;
    end else if (accept_s) begin
      acc_r <= acc_next_s;
      err_r <= err_r || !digit_ok_s;
    end else begin
      acc_r <= acc_r;
      err_r <= err_r;
    end
  end

  // word result, held until the next completion
  always_ff @(posedge clk) begin
    if (rst) begin
      gt_r <= 1'b0;
      lt_r <= 1'b0;
      eq_r <= 1'b0;
    end else if (finish_s) begin
      gt_r <= (acc_next_s == GREATER);
      lt_r <= (acc_next_s == LESS);
      eq_r <= (acc_next_s == EQUAL);
    end else begin
      gt_r <= gt_r;
      lt_r <= lt_r;
      eq_r <= eq_r;
    end
  end

  assign dig_ready = dig_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign gt        = gt_r;
  assign lt        = lt_r;
  assign eq        = eq_r;
  assign err       = err_r;

endmodule

// File: tb/tb_cmp_digit_serial.sv
// Self-checking bench for cmp_digit_serial: NDIGITS=4 and NDIGITS=1 instances,
// directed cases plus randomized words checked against a word-level reference model.
module tb_cmp_digit_serial;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start_v, valid_v;
  logic [2:0] dig_v [2];
  wire  [1:0] rdy_v, busy_v, done_v, gt_v, lt_v, eq_v, err_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_digit_serial #(.NDIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .dig_valid(valid_v[0]), .dig_ready(rdy_v[0]),
    .g_in(dig_v[0][2]), .l_in(dig_v[0][1]), .e_in(dig_v[0][0]),
    .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .lt(lt_v[0]), .eq(eq_v[0]), .err(err_v[0])
  );

  cmp_digit_serial #(.NDIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .dig_valid(valid_v[1]), .dig_ready(rdy_v[1]),
    .g_in(dig_v[1][2]), .l_in(dig_v[1][1]), .e_in(dig_v[1][0]),
    .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .lt(lt_v[1]), .eq(eq_v[1]), .err(err_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word-level reference: first well-formed g/l digit (MSB first) decides the word.
  function automatic void model(input logic [2:0] d [16], input int nd,
                                output int used, output logic [2:0] res, output logic e);
    int  verdict;
    logic oh;
    verdict = 0;
    e = 1'b0;
    used = nd;
    for (int i = 0; i < nd; i++) begin
      oh = ($countones(d[i]) == 1);
      if (!oh) e = 1'b1;
      if (verdict == 0 && oh && d[i] == 3'b100) verdict = 1;
      else if (verdict == 0 && oh && d[i] == 3'b010) verdict = 2;
`ifdef CMP_EARLY_EXIT_EN
      if (verdict != 0) begin
        used = i + 1;
        break;
      end
`endif
    end
    res = (verdict == 1) ? 3'b100 : (verdict == 2) ? 3'b010 : 3'b001;
  endfunction

  // Split two 8-bit words into MSB-first 2-bit digit comparisons.
  function automatic void words(input logic [7:0] a, input logic [7:0] b, output logic [2:0] d [16]);
    int ad, bd;
    for (int k = 0; k < 16; k++) d[k] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      ad = int'(a >> (6 - 2 * k)) & 3;
      bd = int'(b >> (6 - 2 * k)) & 3;
      d[k] = (ad > bd) ? 3'b100 : (ad < bd) ? 3'b010 : 3'b001;
    end
  endfunction

  task automatic check_idle_reset(input int s);
    chk("rst_ready", rdy_v[s], 0);
    chk("rst_busy", busy_v[s], 0);
    chk("rst_done", done_v[s], 0);
    chk("rst_result", {gt_v[s], lt_v[s], eq_v[s]}, 0);
    chk("rst_err", err_v[s], 0);
  endtask

  // One full compare on instance s. gap<0 means random 0..2 idle cycles per digit.
  task automatic run(input int s, input logic [2:0] d [16], input int gap, input bit noise);
    int nd, used, g;
    logic [2:0] res;
    logic e;
    nd = (s == 0) ? 4 : 1;
    model(d, nd, used, res, e);
    @(negedge clk);
    start_v[s] = 1'b1;
    valid_v[s] = 1'b0;
    @(negedge clk);
    start_v[s] = 1'b0;
    chk("busy_start", busy_v[s], 1);
    chk("ready_start", rdy_v[s], 1);
    chk("err_clear", err_v[s], 0);
    chk("done_early", done_v[s], 0);
    for (int i = 0; i < used; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        start_v[s] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        valid_v[s] = 1'b0;
        dig_v[s]   = 3'($urandom);
        @(negedge clk);
        chk("stall_busy", busy_v[s], 1);
        chk("stall_done", done_v[s], 0);
      end
      start_v[s] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      valid_v[s] = 1'b1;
      dig_v[s]   = d[i];
      @(negedge clk);
      valid_v[s] = 1'b0;
      start_v[s] = 1'b0;
      if (i < used - 1) begin
        chk("mid_done", done_v[s], 0);
        chk("mid_busy", busy_v[s], 1);
      end
    end
    chk("done_pulse", done_v[s], 1);
    chk("busy_off", busy_v[s], 0);
    chk("ready_off", rdy_v[s], 0);
    chk("result", {gt_v[s], lt_v[s], eq_v[s]}, res);
    chk("err", err_v[s], e);
    // start and a digit offered during DONE must both be ignored
    start_v[s] = 1'b1;
    valid_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    valid_v[s] = 1'b0;
    chk("done_once", done_v[s], 0);
    chk("idle_busy", busy_v[s], 0);
    chk("result_hold", {gt_v[s], lt_v[s], eq_v[s]}, res);
    @(negedge clk);
    chk("start_in_done_ignored", busy_v[s], 0);
  endtask

  logic [2:0] d [16];
  logic [2:0] bad [5];

  initial begin
    bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    rst = 1'b1;
    start_v = 2'b00;
    valid_v = 2'b00;
    dig_v[0] = 3'b000;
    dig_v[1] = 3'b000;
    repeat (3) @(negedge clk);
    check_idle_reset(0);
    check_idle_reset(1);
    rst = 1'b0;
    @(negedge clk);
    check_idle_reset(0);

    // equal words A5/A5
    words(8'hA5, 8'hA5, d);
    run(0, d, 0, 1'b0);
    // C0 vs 40: MSB digit decides
    words(8'hC0, 8'h40, d);
    run(0, d, 0, 1'b0);
    // e,l,g,e with 2-cycle gaps
    for (int k = 0; k < 16; k++) d[k] = 3'b001;
    d[1] = 3'b010;
    d[2] = 3'b100;
    run(0, d, 2, 1'b0);
    // malformed second digit, then a clean compare clears err
    for (int k = 0; k < 16; k++) d[k] = 3'b001;
    d[1] = 3'b110;
    run(0, d, 0, 1'b0);
    words(8'h12, 8'h13, d);
    run(0, d, 0, 1'b0);

    // reset on the third digit of a run
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    valid_v[0] = 1'b1;
    dig_v[0]   = 3'b001;
    repeat (2) @(negedge clk);
    dig_v[0] = 3'b100;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    valid_v[0] = 1'b0;
    check_idle_reset(0);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", done_v[0], 0);
      chk("post_rst_busy", busy_v[0], 0);
    end
    words(8'h7F, 8'h3F, d);
    run(0, d, 0, 1'b0);

    // randomized words, optional corruption, gaps and stray starts
    for (int it = 0; it < 40; it++) begin
      words(8'($urandom), 8'($urandom), d);
      if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 3)] = bad[$urandom_range(0, 4)];
      run(0, d, -1, 1'b1);
    end

    // single-digit instance
    for (int k = 0; k < 16; k++) d[k] = 3'b001;
    d[0] = 3'b010;
    run(1, d, 0, 1'b1);
    for (int it = 0; it < 12; it++) begin
      d[0] = ($urandom_range(0, 5) == 0) ? bad[$urandom_range(0, 4)] : (3'b001 << $urandom_range(0, 2));
      run(1, d, -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
